// File: rtl/lrp_alpha_gen_if.sv
// ---------------------------------------------------------------------------
// lrp_alpha_gen_if
// Handshake/data bundle between the LRP alpha generator and its producer /
// consumer.
//   in_ctr_start  : begin new frame (pulse)
//   in_ctr_valid  : in_rel valid this cycle
//   in_rel        : reliability magnitude of the current symbol (unsigned)
//   in_ack        : consumer takes the held result
//   out_valid     : result valid, held until in_ack
//   out_busy      : frame collection in progress
//   out_alpha1..3 : packed {a^5j, a^3j, a^j} for the 1st..3rd least reliable
//   out_pos       : {pos3,pos2,pos1}, only when TSG_LRP_POS_OUT_EN is defined
// Modports: master = frame source / result consumer, slave = generator.
// ---------------------------------------------------------------------------
interface lrp_alpha_gen_if #(
    parameter int GF_LEN = 10,
    parameter int REL_W  = 4
`ifdef TSG_LRP_POS_OUT_EN
    , parameter int IDX_W = 10
`endif
);
    logic                  in_ctr_start;
    logic                  in_ctr_valid;
    logic [REL_W-1:0]      in_rel;
    logic                  in_ack;
    logic                  out_valid;
    logic                  out_busy;
    logic [3*GF_LEN-1:0]   out_alpha1;
    logic [3*GF_LEN-1:0]   out_alpha2;
    logic [3*GF_LEN-1:0]   out_alpha3;
`ifdef TSG_LRP_POS_OUT_EN
    logic [3*IDX_W-1:0]    out_pos;
`endif

    modport master (
        output in_ctr_start, in_ctr_valid, in_rel, in_ack,
        input  out_valid, out_busy, out_alpha1, out_alpha2, out_alpha3
`ifdef TSG_LRP_POS_OUT_EN
        , input out_pos
`endif
    );

    modport slave (
        input  in_ctr_start, in_ctr_valid, in_rel, in_ack,
        output out_valid, out_busy, out_alpha1, out_alpha2, out_alpha3
`ifdef TSG_LRP_POS_OUT_EN
        , output out_pos
`endif
    );
endinterface

// File: rtl/lrp_alpha_gen.sv
// ---------------------------------------------------------------------------
// lrp_alpha_gen
// Feeds the 3-case test syndrome generator of the Chase BCH decoder. It
// scans one frame of CODE_LEN reliability magnitudes, keeps the three least
// reliable positions sorted ascending by reliability, and presents for each
// of them the packed powers {a^5j, a^3j, a^j}. The result is held under a
// valid/ack handshake.
// Ports:
//   clk           : clock, rising edge
//   in_ctr_Arstn  : asynchronous active-low reset
//   in_ctr_Srst   : synchronous clear, same effect as reset
//   io_lrp        : lrp_alpha_gen_if.slave (start/valid/rel/ack in,
//                   valid/busy/alpha1..3[/pos] out)
// Optional feature: define TSG_LRP_POS_OUT_EN to add out_pos and the index
// slot registers behind it.
// ---------------------------------------------------------------------------
module lrp_alpha_gen #(
    parameter int              GF_LEN    = 10,
    parameter logic [GF_LEN:0] PRIM_POLY = 11'h409,
    parameter int              CODE_LEN  = 1023,
    parameter int              REL_W     = 4,
    parameter int              IDX_W     = 10
) (
    input  logic           clk,
    input  logic           in_ctr_Arstn,
    input  logic           in_ctr_Srst,
    lrp_alpha_gen_if.slave io_lrp
);
    localparam int               AW       = 3 * GF_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);
    localparam logic [GF_LEN-1:0] GF_ONE  = GF_LEN'(1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

    // Multiply by a: shift up and reduce by the primitive polynomial.
    function automatic logic [GF_LEN-1:0] gf_xtime(input logic [GF_LEN-1:0] x);
        logic [GF_LEN:0] t;
        t = {x, 1'b0};
        if (t[GF_LEN]) t = t ^ PRIM_POLY;
        return t[GF_LEN-1:0];
    endfunction

    // Multiply by the constant a^k as a chain of k xtime stages.
    function automatic logic [GF_LEN-1:0] gf_mul_apow(input logic [GF_LEN-1:0] x,
                                                       input int k);
        logic [GF_LEN-1:0] y;
        y = x;
        for (int i = 0; i < k; i++) y = gf_xtime(y);
        return y;
    endfunction

    state_t                      r_state, w_state_nxt;
    logic                        w_load, w_accept, w_done;
    logic [IDX_W-1:0]            r_idx;
    logic [GF_LEN-1:0]           r_p1, r_p3, r_p5;
    logic [2:0][REL_W-1:0]       r_slot_rel,   w_nxt_rel;
    logic [2:0][AW-1:0]          r_slot_alpha, w_nxt_alpha;
    logic [2:0][AW-1:0]          r_out_alpha;
    logic [AW-1:0]               w_new_alpha;
`ifdef TSG_LRP_POS_OUT_EN
    logic [2:0][IDX_W-1:0]       r_slot_pos,   w_nxt_pos;
    logic [2:0][IDX_W-1:0]       r_out_pos;
`endif

    logic             w_start, w_valid, w_ack;
    logic [REL_W-1:0] w_rel;

    assign w_start     = io_lrp.in_ctr_start;
    assign w_valid     = io_lrp.in_ctr_valid;
    assign w_ack       = io_lrp.in_ack;
    assign w_rel       = io_lrp.in_rel;
    assign w_new_alpha = {r_p5, r_p3, r_p1};

    // FSM state register
    always_ff @(posedge clk or negedge in_ctr_Arstn) begin
        if (!in_ctr_Arstn)    r_state <= S_IDLE;
        else if (in_ctr_Srst) r_state <= S_IDLE;
        else                  r_state <= w_state_nxt;
    end

    // FSM next state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_COLLECT;
                    w_load      = 1'b1;
                end
            end
            S_COLLECT: begin
                // A start here restarts the frame; the symbol on that
                // cycle is not taken.
                if (w_start) begin
                    w_load = 1'b1;
                end else if (w_valid) begin
                    w_accept = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_ack) begin
                    if (w_start) begin
                        w_state_nxt = S_COLLECT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sorted insertion: strict compares keep the earlier position on ties.
    always_comb begin
        w_nxt_rel   = r_slot_rel;
        w_nxt_alpha = r_slot_alpha;
`ifdef TSG_LRP_POS_OUT_EN
        w_nxt_pos   = r_slot_pos;
`endif
        if (w_rel < r_slot_rel[0]) begin
            w_nxt_rel[2]   = r_slot_rel[1];
            w_nxt_rel[1]   = r_slot_rel[0];
            w_nxt_rel[0]   = w_rel;
            w_nxt_alpha[2] = r_slot_alpha[1];
            w_nxt_alpha[1] = r_slot_alpha[0];
            w_nxt_alpha[0] = w_new_alpha;
`ifdef TSG_LRP_POS_OUT_EN
            w_nxt_pos[2]   = r_slot_pos[1];
            w_nxt_pos[1]   = r_slot_pos[0];
            w_nxt_pos[0]   = r_idx;
`endif
        end else if (w_rel < r_slot_rel[1]) begin
            w_nxt_rel[2]   = r_slot_rel[1];
            w_nxt_rel[1]   = w_rel;
            w_nxt_alpha[2] = r_slot_alpha[1];
            w_nxt_alpha[1] = w_new_alpha;
`ifdef TSG_LRP_POS_OUT_EN
            w_nxt_pos[2]   = r_slot_pos[1];
            w_nxt_pos[1]   = r_idx;
`endif
        end else if (w_rel < r_slot_rel[2]) begin
            w_nxt_rel[2]   = w_rel;
            w_nxt_alpha[2] = w_new_alpha;
`ifdef TSG_LRP_POS_OUT_EN
            w_nxt_pos[2]   = r_idx;
`endif
        end
    end

    // Collection registers: slots, position counter and running powers
    always_ff @(posedge clk or negedge in_ctr_Arstn) begin
        if (!in_ctr_Arstn) begin
            r_slot_rel   <= '1;
            r_slot_alpha <= '0;
            r_idx        <= '0;
            r_p1         <= GF_ONE;
            r_p3         <= GF_ONE;
            r_p5         <= GF_ONE;
        end else if (in_ctr_Srst || w_load) begin
            r_slot_rel   <= '1;
            r_slot_alpha <= '0;
            r_idx        <= '0;
            r_p1         <= GF_ONE;
            r_p3         <= GF_ONE;
            r_p5         <= GF_ONE;
        end else if (w_accept) begin
            r_slot_rel   <= w_nxt_rel;
            r_slot_alpha <= w_nxt_alpha;
            r_idx        <= r_idx + 1'b1;
            r_p1         <= gf_mul_apow(r_p1, 1);
            r_p3         <= gf_mul_apow(r_p3, 3);
            r_p5         <= gf_mul_apow(r_p5, 5);
        end
    end

`ifdef TSG_LRP_POS_OUT_EN
    always_ff @(posedge clk or negedge in_ctr_Arstn) begin
        if (!in_ctr_Arstn)                 r_slot_pos <= '0;
        else if (in_ctr_Srst || w_load)    r_slot_pos <= '0;
        else if (w_accept)                 r_slot_pos <= w_nxt_pos;
    end
`endif

    // Result registers: loaded from the post-insertion slots on the last
    // accept so the final symbol is included with one cycle of latency.
    always_ff @(posedge clk or negedge in_ctr_Arstn) begin
        if (!in_ctr_Arstn) begin
            r_out_alpha <= '0;
`ifdef TSG_LRP_POS_OUT_EN
            r_out_pos   <= '0;
`endif
        end else if (in_ctr_Srst) begin
            r_out_alpha <= '0;
`ifdef TSG_LRP_POS_OUT_EN
            r_out_pos   <= '0;
`endif
        end else if (w_done) begin
            r_out_alpha <= w_nxt_alpha;
`ifdef TSG_LRP_POS_OUT_EN
            r_out_pos   <= w_nxt_pos;
`endif
        end
    end

    assign io_lrp.out_valid  = (r_state == S_HOLD);
    assign io_lrp.out_busy   = (r_state == S_COLLECT);
    assign io_lrp.out_alpha1 = r_out_alpha[0];
    assign io_lrp.out_alpha2 = r_out_alpha[1];
    assign io_lrp.out_alpha3 = r_out_alpha[2];
`ifdef TSG_LRP_POS_OUT_EN
    assign io_lrp.out_pos    = {r_out_pos[2], r_out_pos[1], r_out_pos[0]};
`endif

endmodule

// File: tb/tb_lrp_alpha_gen.sv
// ---------------------------------------------------------------------------
// tb_lrp_alpha_gen
// Directed bench for lrp_alpha_gen over GF(2^4), x^4+x+1, 15-symbol frames.
// Expected alpha words are hand-computed powers of a packed {a^5j,a^3j,a^j}.
// ---------------------------------------------------------------------------
module tb_lrp_alpha_gen;
    localparam int        GF_LEN   = 4;
    localparam logic [4:0] PP      = 5'h13;
    localparam int        CODE_LEN = 15;
    localparam int        REL_W    = 4;
    localparam int        IDX_W    = 4;

    logic clk;
    logic arstn;
    logic srst;

    lrp_alpha_gen_if #(
        .GF_LEN(GF_LEN), .REL_W(REL_W)
`ifdef TSG_LRP_POS_OUT_EN
        , .IDX_W(IDX_W)
`endif
    ) bus ();

    lrp_alpha_gen #(
        .GF_LEN(GF_LEN), .PRIM_POLY(PP), .CODE_LEN(CODE_LEN),
        .REL_W(REL_W), .IDX_W(IDX_W)
    ) dut (
        .clk          (clk),
        .in_ctr_Arstn (arstn),
        .in_ctr_Srst  (srst),
        .io_lrp       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [59:0] rels;   // rel of position i in rels[4*i +: 4]
        bit          gap;
        logic [11:0] a1;
        logic [11:0] a2;
        logic [11:0] a3;
        logic [11:0] pos;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [59:0] fill(input logic [3:0] v);
        logic [59:0] r;
        for (int i = 0; i < 15; i++) r[4*i +: 4] = v;
        return r;
    endfunction

    task automatic start_frame();
        bus.in_ctr_start = 1'b1;
        tick();
        bus.in_ctr_start = 1'b0;
    endtask

    // Sends the first n symbols; early is set if out_valid rises before
    // the 15th accept.
    task automatic send_syms(input logic [59:0] rels, input int n, input bit gap,
                             output bit early);
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                bus.in_ctr_valid = 1'b0;
                bus.in_rel       = 4'd0;
                tick();
                if (bus.out_valid) early = 1'b1;
            end
            bus.in_ctr_valid = 1'b1;
            bus.in_rel       = rels[4*i +: 4];
            tick();
            if (i < 14 && bus.out_valid) early = 1'b1;
        end
        bus.in_ctr_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int k);
        chk({tag, "_valid"},  {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_busy"},   {31'd0, bus.out_busy},  32'd0);
        chk({tag, "_alpha1"}, {20'd0, bus.out_alpha1}, {20'd0, vecs[k].a1});
        chk({tag, "_alpha2"}, {20'd0, bus.out_alpha2}, {20'd0, vecs[k].a2});
        chk({tag, "_alpha3"}, {20'd0, bus.out_alpha3}, {20'd0, vecs[k].a3});
`ifdef TSG_LRP_POS_OUT_EN
        chk({tag, "_pos"},    {20'd0, bus.out_pos},    {20'd0, vecs[k].pos});
`endif
    endtask

    initial begin
        bit early;
        bit stable;

        // pos2=1, pos7=0, pos11=3, rest 15
        vecs[0].rels = fill(4'd15);
        vecs[0].rels[4*2 +: 4]  = 4'd1;
        vecs[0].rels[4*7 +: 4]  = 4'd0;
        vecs[0].rels[4*11 +: 4] = 4'd3;
        vecs[0].gap = 1'b0;
        vecs[0].a1 = 12'h6CB; vecs[0].a2 = 12'h7C4; vecs[0].a3 = 12'h78E;
        vecs[0].pos = 12'hB27;
        // all ties
        vecs[1].rels = fill(4'd5);
        vecs[1].gap = 1'b0;
        vecs[1].a1 = 12'h111; vecs[1].a2 = 12'h682; vecs[1].a3 = 12'h7C4;
        vecs[1].pos = 12'h210;
        // same as vector 0 with valid gaps
        vecs[2] = vecs[0];
        vecs[2].gap = 1'b1;
        // descending rel = 15-i: winners pos14, pos13, pos12
        for (int i = 0; i < 15; i++) vecs[3].rels[4*i +: 4] = 4'(15 - i);
        vecs[3].gap = 1'b0;
        vecs[3].a1 = 12'h7F9; vecs[3].a2 = 12'h6AD; vecs[3].a3 = 12'h1CF;
        vecs[3].pos = 12'hCDE;

        arstn = 1'b0;
        srst  = 1'b0;
        bus.in_ctr_start = 1'b0;
        bus.in_ctr_valid = 1'b0;
        bus.in_rel       = 4'd0;
        bus.in_ack       = 1'b0;
        tick();
        tick();
        chk("rst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy",   {31'd0, bus.out_busy},  32'd0);
        chk("rst_alpha1", {20'd0, bus.out_alpha1}, 32'd0);
        chk("rst_alpha3", {20'd0, bus.out_alpha3}, 32'd0);
        arstn = 1'b1;
        tick();

        // Table-driven frames
        for (int k = 0; k < 4; k++) begin
            start_frame();
            chk($sformatf("v%0d_busy_start", k), {31'd0, bus.out_busy}, 32'd1);
            send_syms(vecs[k].rels, 15, vecs[k].gap, early);
            chk($sformatf("v%0d_no_early_valid", k), {31'd0, early}, 32'd0);
            check_result($sformatf("v%0d", k), k);
            tick();
            chk($sformatf("v%0d_valid_held", k), {31'd0, bus.out_valid}, 32'd1);
            bus.in_ack = 1'b1;
            tick();
            bus.in_ack = 1'b0;
            chk($sformatf("v%0d_valid_after_ack", k), {31'd0, bus.out_valid}, 32'd0);
        end

        // Abort at idx=6, then the tie frame
        begin
            logic [59:0] part;
            part = fill(4'd15);
            part[4*3 +: 4] = 4'd0;
            part[4*4 +: 4] = 4'd0;
            part[4*5 +: 4] = 4'd0;
            start_frame();
            send_syms(part, 6, 1'b0, early);
            chk("abort_no_valid", {31'd0, (early | bus.out_valid)}, 32'd0);
            start_frame();
            chk("abort_busy", {31'd0, bus.out_busy}, 32'd1);
            send_syms(vecs[1].rels, 15, 1'b0, early);
            chk("abort_no_early_valid", {31'd0, early}, 32'd0);
            check_result("abort", 1);
            bus.in_ack = 1'b1;
            tick();
            bus.in_ack = 1'b0;
        end

        // HOLD ignores start/valid without ack, then back-to-back frame
        start_frame();
        send_syms(vecs[0].rels, 15, 1'b0, early);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.in_ctr_start = (c % 4 == 1);
            bus.in_ctr_valid = 1'b1;
            bus.in_rel       = 4'd0;
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_busy !== 1'b0 ||
                bus.out_alpha1 !== vecs[0].a1 || bus.out_alpha2 !== vecs[0].a2 ||
                bus.out_alpha3 !== vecs[0].a3)
                stable = 1'b0;
        end
        bus.in_ctr_start = 1'b0;
        bus.in_ctr_valid = 1'b0;
        chk("hold_stable", {31'd0, stable}, 32'd1);
        bus.in_ack       = 1'b1;
        bus.in_ctr_start = 1'b1;
        tick();
        bus.in_ctr_start = 1'b0;
        chk("b2b_valid_low", {31'd0, bus.out_valid}, 32'd0);
        chk("b2b_busy",      {31'd0, bus.out_busy},  32'd1);
        // ack held high through COLLECT must be ignored
        send_syms(vecs[1].rels, 15, 1'b0, early);
        chk("b2b_no_early_valid", {31'd0, early}, 32'd0);
        check_result("b2b", 1);
        tick();
        bus.in_ack = 1'b0;
        chk("b2b_ack_idle", {31'd0, bus.out_valid}, 32'd0);

        // Async reset mid-frame, then a fresh frame
        start_frame();
        send_syms(vecs[3].rels, 8, 1'b0, early);
        #3;
        arstn = 1'b0;
        #1;
        chk("arst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("arst_busy",   {31'd0, bus.out_busy},  32'd0);
        chk("arst_alpha1", {20'd0, bus.out_alpha1}, 32'd0);
        chk("arst_alpha2", {20'd0, bus.out_alpha2}, 32'd0);
        chk("arst_alpha3", {20'd0, bus.out_alpha3}, 32'd0);
        tick();
        tick();
        arstn = 1'b1;
        tick();
        start_frame();
        send_syms(vecs[0].rels, 15, 1'b0, early);
        chk("post_arst_no_early_valid", {31'd0, early}, 32'd0);
        check_result("post_arst", 0);

        // Synchronous clear from HOLD
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_valid",  {31'd0, bus.out_valid}, 32'd0);
        chk("srst_busy",   {31'd0, bus.out_busy},  32'd0);
        chk("srst_alpha1", {20'd0, bus.out_alpha1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
